// File: rtl/fp_to_int_pipe_if.sv
// Operand/result stream bundle for fp_to_int_pipe.
// Valid/ready: a word moves on a rising edge where valid and ready are both 1; once valid
// is raised the sender holds its payload stable until that edge, and ready may depend on valid.
interface fp_to_int_pipe_if #(
  parameter int FPWID  = 64,
  parameter int IWID   = 64,
  parameter int TAGWID = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [FPWID-1:0]  i;
  logic              op;
  logic [2:0]        rm;
  logic [TAGWID-1:0] in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [IWID-1:0]   o;
  logic              nv;
  logic              nx;
  logic [TAGWID-1:0] out_tag;

  modport master (output in_valid, i, op, rm, in_tag, out_ready,
                  input  in_ready, out_valid, o, nv, nx, out_tag);
  modport slave  (input  in_valid, i, op, rm, in_tag, out_ready,
                  output in_ready, out_valid, o, nv, nx, out_tag);
endinterface

// File: rtl/fp_to_int_pipe.sv
// Three-stage IEEE 754 binary to integer converter: decode/classify, align shift,
// round/negate/saturate, with a valid/ready register after every stage.
module fp_to_int_pipe #(
  parameter int FPWID  = 64,
  parameter int EXPWID = 11,
  parameter int IWID   = 64,
  parameter int TAGWID = 8
) (
  input logic             clk,
  input logic             rst,
  fp_to_int_pipe_if.slave bus
);
  localparam int FMSB = FPWID - EXPWID - 2;
  localparam int MW   = FMSB + 2;
  localparam int BIAS = 2**(EXPWID-1) - 1;
  localparam int SHW  = $clog2(IWID + 2);
  localparam int VW   = IWID + 2 + MW;
  localparam logic [IWID+1:0] SMAX     = {3'b000, {(IWID-1){1'b1}}};
  localparam logic [IWID+1:0] SMIN_MAG = {3'b001, {(IWID-1){1'b0}}};
  localparam logic [IWID+1:0] UMAX     = {2'b00, {IWID{1'b1}}};

  logic              s1_v, s1_sign, s1_op, s1_nan, s1_ovf, s1_tiny;
  logic [2:0]        s1_rm;
  logic [TAGWID-1:0] s1_tag;
  logic [MW-1:0]     s1_man;
  logic [SHW-1:0]    s1_sh;
  logic              s2_v, s2_sign, s2_op, s2_nan, s2_ovf, s2_g, s2_st;
  logic [2:0]        s2_rm;
  logic [TAGWID-1:0] s2_tag;
  logic [IWID:0]     s2_int;
  logic              s3_v, s3_nv, s3_nx;
  logic [IWID-1:0]   s3_o;
  logic [TAGWID-1:0] s3_tag;
  logic              ld1, ld2, ld3;

  // A register loads when it is empty or its content leaves on the same edge.
  assign ld3 = ~s3_v | bus.out_ready;
  assign ld2 = ~s2_v | ld3;
  assign ld1 = ~s1_v | ld2;

  assign bus.in_ready  = ld1;
  assign bus.out_valid = s3_v;
  assign bus.o         = s3_o;
  assign bus.nv        = s3_nv;
  assign bus.nx        = s3_nx;
  assign bus.out_tag   = s3_tag;

  logic [EXPWID-1:0] exp_d;
  logic [FMSB:0]     frac_d;
  int                e_d;
  logic              exp_max, exp_zero;
  logic              s1_nan_d, s1_ovf_d, s1_tiny_d;
  logic [MW-1:0]     s1_man_d;
  logic [SHW-1:0]    s1_sh_d;

  // Shift amount places the 2^IWID weight at the top of the align window; magnitudes
  // below 0.5 bypass the shifter as pure sticky, oversized exponents as overflow.
  always_comb begin
    exp_d     = bus.i[FPWID-2 -: EXPWID];
    frac_d    = bus.i[FMSB:0];
    exp_max   = &exp_d;
    exp_zero  = (exp_d == '0);
    e_d       = 32'(exp_d) - BIAS;
    s1_nan_d  = exp_max & (|frac_d);
    s1_ovf_d  = exp_max ? ~(|frac_d) : (e_d >= IWID + 1);
    s1_tiny_d = ~exp_max & ~exp_zero & (e_d < -1);
    s1_man_d  = exp_zero ? '0 : {1'b1, frac_d};
    s1_sh_d   = '0;
    if (e_d >= -1 && e_d <= IWID) s1_sh_d = SHW'(IWID - e_d);
  end

  logic [VW-1:0] s2_vec;
  logic [IWID:0] s2_int_d;
  logic          s2_g_d, s2_st_d;

  always_comb begin
    s2_vec   = {s1_man, {(IWID+2){1'b0}}} >> s1_sh;
    s2_int_d = s2_vec[VW-1 -: IWID+1];
    s2_g_d   = s2_vec[MW];
    s2_st_d  = |s2_vec[MW-1:0];
    if (s1_tiny) begin
      s2_int_d = '0;
      s2_g_d   = 1'b0;
      s2_st_d  = 1'b1;
    end
  end

  logic            inc, rng_pos, rng_neg, sat_pos, sat_neg, nv_d, nx_d;
  logic [IWID+1:0] mag;
  logic [IWID-1:0] mag_lo, o_d;

  // Range is judged on the rounded magnitude, so -2^(IWID-1) stays representable.
  always_comb begin
    case (s2_rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = s2_sign & (s2_g | s2_st);
      3'd3:    inc = ~s2_sign & (s2_g | s2_st);
      3'd4:    inc = s2_g;
      default: inc = s2_g & (s2_st | s2_int[0]);
    endcase
    mag     = {1'b0, s2_int} + {{(IWID+1){1'b0}}, inc};
    rng_pos = s2_op ? (mag > SMAX) : (mag > UMAX);
    rng_neg = s2_op ? (mag > SMIN_MAG) : (mag != '0);
    sat_pos = s2_nan | (~s2_sign & (s2_ovf | rng_pos));
    sat_neg = ~s2_nan & s2_sign & (s2_ovf | rng_neg);
    mag_lo  = mag[IWID-1:0];
    o_d     = s2_sign ? -mag_lo : mag_lo;
    nv_d    = 1'b0;
    nx_d    = s2_g | s2_st;
    if (sat_pos) begin
      o_d  = s2_op ? {1'b0, {(IWID-1){1'b1}}} : '1;
      nv_d = 1'b1;
      nx_d = 1'b0;
    end else if (sat_neg) begin
      o_d  = s2_op ? {1'b1, {(IWID-1){1'b0}}} : '0;
      nv_d = 1'b1;
      nx_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0; s1_sign <= 1'b0; s1_op <= 1'b0; s1_rm <= '0; s1_tag <= '0;
      s1_nan <= 1'b0; s1_ovf <= 1'b0; s1_tiny <= 1'b0; s1_man <= '0; s1_sh <= '0;
      s2_v <= 1'b0; s2_sign <= 1'b0; s2_op <= 1'b0; s2_rm <= '0; s2_tag <= '0;
      s2_nan <= 1'b0; s2_ovf <= 1'b0; s2_int <= '0; s2_g <= 1'b0; s2_st <= 1'b0;
      s3_v <= 1'b0; s3_o <= '0; s3_nv <= 1'b0; s3_nx <= 1'b0; s3_tag <= '0;
    end else begin
      if (ld1) s1_v <= bus.in_valid;
      if (ld1 & bus.in_valid) begin
        s1_sign <= bus.i[FPWID-1];
        s1_op   <= bus.op;
        s1_rm   <= bus.rm;
        s1_tag  <= bus.in_tag;
        s1_nan  <= s1_nan_d;
        s1_ovf  <= s1_ovf_d;
        s1_tiny <= s1_tiny_d;
        s1_man  <= s1_man_d;
        s1_sh   <= s1_sh_d;
      end
      if (ld2) s2_v <= s1_v;
      if (ld2 & s1_v) begin
        s2_sign <= s1_sign;
        s2_op   <= s1_op;
        s2_rm   <= s1_rm;
        s2_tag  <= s1_tag;
        s2_nan  <= s1_nan;
        s2_ovf  <= s1_ovf;
        s2_int  <= s2_int_d;
        s2_g    <= s2_g_d;
        s2_st   <= s2_st_d;
      end
      if (ld3) s3_v <= s2_v;
      if (ld3 & s2_v) begin
        s3_o   <= o_d;
        s3_nv  <= nv_d;
        s3_nx  <= nx_d;
        s3_tag <= s2_tag;
      end
    end
  end
endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Self-checking bench for fp_to_int_pipe: directed vectors, latency, throughput,
// stalled random stream with tags, and reset in the middle of a stream.
module tb_fp_to_int_pipe;
  localparam int FPWID  = 64;
  localparam int EXPWID = 11;
  localparam int IWID   = 64;
  localparam int TAGWID = 8;
  localparam int EW     = TAGWID + 2 + IWID;

  typedef struct packed {
    logic [63:0] i;
    logic        op;
    logic [2:0]  rm;
    logic [63:0] o;
    logic        nv;
    logic        nx;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  fp_to_int_pipe_if #(.FPWID(FPWID), .IWID(IWID), .TAGWID(TAGWID)) bus ();

  fp_to_int_pipe #(.FPWID(FPWID), .EXPWID(EXPWID), .IWID(IWID), .TAGWID(TAGWID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] mk_fp(input logic s, input int unsigned n, input int q);
    real r;
    r = real'(n) + real'(q) / 4.0;
    if (s) r = -r;
    return $realtobits(r);
  endfunction

  // Value is (n + q/4) with the given sign; q selects the fractional quarter.
  function automatic logic [EW-1:0] model(input logic s, input int unsigned n, input int q,
                                          input logic op, input logic [2:0] rm,
                                          input logic [TAGWID-1:0] tag);
    logic up, nv, nx;
    logic [63:0] mag, o;
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = s && (q != 0);
      3'd3:    up = !s && (q != 0);
      3'd4:    up = (q >= 2);
      default: up = (q == 3) || (q == 2 && n[0]);
    endcase
    mag = 64'(n) + 64'(up);
    nx  = (q != 0);
    nv  = 1'b0;
    if (!s)            o = mag;
    else if (op)       o = -mag;
    else if (mag == 0) o = '0;
    else begin
      o  = '0;
      nv = 1'b1;
      nx = 1'b0;
    end
    return {tag, nv, nx, o};
  endfunction

  // ---------------- driver ----------------
  task automatic drive_op(input logic [63:0] fp, input logic op, input logic [2:0] rm,
                          input logic [TAGWID-1:0] tag, input logic [EW-1:0] expv);
    logic acc;
    int waited;
    acc = 1'b0;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.i = fp;
    bus.op = op;
    bus.rm = rm;
    bus.in_tag = tag;
    while (!acc && waited < 300) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (acc) exp_q.push_back(expv);
    else begin
      errors++;
      $display("FAIL drive_accept tag=%0h: in_ready stayed 0 for %0d cycles, required 1", tag, waited);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %0b, required 0", bus.out_valid);
    end
    checks++;
    if ({bus.out_tag, bus.nv, bus.nx, bus.o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got tag=%0h nv=%0b nx=%0b o=%h, required all 0",
               bus.out_tag, bus.nv, bus.nx, bus.o);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b, required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.i = 64'h3FF8000000000000;
    bus.op = 1'b1;
    bus.rm = 3'd0;
    bus.in_tag = 8'h3C;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL lat_in_ready: got %0b, required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL lat_early edge=%0d: out_valid got %0b, required 0", k, bus.out_valid);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if ({bus.out_valid, bus.out_tag, bus.nv, bus.nx, bus.o} !== {1'b1, 8'h3C, 1'b0, 1'b1, 64'd2}) begin
      errors++;
      $display("FAIL lat_result: got valid=%0b tag=%0h nv=%0b nx=%0b o=%h, required valid=1 tag=3c nv=0 nx=1 o=2",
               bus.out_valid, bus.out_tag, bus.nv, bus.nx, bus.o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    localparam int N = 24;
    vec_t tab [N];
    tab[0]  = '{64'h4004000000000000, 1'b1, 3'd0, 64'd2, 1'b0, 1'b1};
    tab[1]  = '{64'h4004000000000000, 1'b1, 3'd4, 64'd3, 1'b0, 1'b1};
    tab[2]  = '{64'hC004000000000000, 1'b1, 3'd2, 64'hFFFFFFFFFFFFFFFD, 1'b0, 1'b1};
    tab[3]  = '{64'h43E0000000000000, 1'b1, 3'd0, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b0};
    tab[4]  = '{64'h43E0000000000000, 1'b0, 3'd0, 64'h8000000000000000, 1'b0, 1'b0};
    tab[5]  = '{64'hC3E0000000000000, 1'b1, 3'd0, 64'h8000000000000000, 1'b0, 1'b0};
    tab[6]  = '{64'h7FF8000000000000, 1'b1, 3'd0, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b0};
    tab[7]  = '{64'hBFF0000000000000, 1'b0, 3'd0, 64'h0, 1'b1, 1'b0};
    tab[8]  = '{64'hBFD3333333333333, 1'b0, 3'd1, 64'h0, 1'b0, 1'b1};
    tab[9]  = '{64'h0000000000000000, 1'b1, 3'd0, 64'h0, 1'b0, 1'b0};
    tab[10] = '{64'h8000000000000000, 1'b1, 3'd2, 64'h0, 1'b0, 1'b0};
    tab[11] = '{64'h7FF0000000000000, 1'b0, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0};
    tab[12] = '{64'hFFF0000000000000, 1'b1, 3'd0, 64'h8000000000000000, 1'b1, 1'b0};
    tab[13] = '{64'h43F0000000000000, 1'b0, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0};
    tab[14] = '{64'h7E37E43C8800759C, 1'b1, 3'd1, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b0};
    tab[15] = '{64'hC3E0000000000001, 1'b1, 3'd1, 64'h8000000000000000, 1'b1, 1'b0};
    tab[16] = '{64'h3FE0000000000000, 1'b1, 3'd0, 64'h0, 1'b0, 1'b1};
    tab[17] = '{64'h3FE0000000000000, 1'b1, 3'd3, 64'd1, 1'b0, 1'b1};
    tab[18] = '{64'hBFE0000000000000, 1'b1, 3'd2, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1};
    tab[19] = '{64'h3FC0000000000000, 1'b1, 3'd3, 64'd1, 1'b0, 1'b1};
    tab[20] = '{64'h43DFFFFFFFFFFFFF, 1'b1, 3'd0, 64'h7FFFFFFFFFFFFC00, 1'b0, 1'b0};
    tab[21] = '{64'hBFE6666666666666, 1'b0, 3'd3, 64'h0, 1'b0, 1'b1};
    tab[22] = '{64'h4004000000000000, 1'b1, 3'd6, 64'd2, 1'b0, 1'b1};
    tab[23] = '{64'h43EFFFFFFFFFFFFF, 1'b0, 3'd0, 64'hFFFFFFFFFFFFF800, 1'b0, 1'b0};
    bus.out_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < N; k++)
          drive_op(tab[k].i, tab[k].op, tab[k].rm, TAGWID'(k),
                   {TAGWID'(k), tab[k].nv, tab[k].nx, tab[k].o});
      end
      begin
        int got, cyc, first, last;
        logic [EW-1:0] ev;
        got = 0; cyc = 0; first = -1; last = -1;
        while (got < N && cyc < 400) begin
          @(negedge clk);
          cyc++;
          if (bus.out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL bb_unexpected: result tag=%0h with nothing pending", bus.out_tag);
            end else begin
              ev = exp_q.pop_front();
              if ({bus.out_tag, bus.nv, bus.nx, bus.o} !== ev) begin
                errors++;
                $display("FAIL bb_result: got tag=%0h nv=%0b nx=%0b o=%h, required tag=%0h nv=%0b nx=%0b o=%h",
                         bus.out_tag, bus.nv, bus.nx, bus.o,
                         ev[EW-1 -: TAGWID], ev[IWID+1], ev[IWID], ev[IWID-1:0]);
              end
            end
            got++;
            if (first < 0) first = cyc;
            last = cyc;
          end
        end
        checks++;
        if (got != N) begin
          errors++;
          $display("FAIL bb_count: got %0d results, required %0d", got, N);
        end
        checks++;
        if (last - first != N - 1) begin
          errors++;
          $display("FAIL bb_throughput: results spread over %0d cycles, required %0d", last - first + 1, N);
        end
      end
    join
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall_stream();
    localparam int N = 8;
    bus.out_ready = 1'($urandom_range(0, 1));
    fork
      begin
        for (int k = 0; k < N; k++) begin
          logic s, op;
          int unsigned n;
          int q;
          logic [2:0] rm;
          s  = 1'($urandom_range(0, 1));
          op = 1'($urandom_range(0, 1));
          n  = $urandom_range(0, 1 << 20);
          q  = $urandom_range(0, 3);
          rm = 3'($urandom_range(0, 7));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          drive_op(mk_fp(s, n, q), op, rm, TAGWID'(k), model(s, n, q, op, rm, TAGWID'(k)));
        end
      end
      begin
        int got, cyc;
        logic was_stalled;
        logic [EW-1:0] held, ev;
        got = 0; cyc = 0; was_stalled = 1'b0; held = '0;
        while (got < N && cyc < 600) begin
          @(negedge clk);
          cyc++;
          if (was_stalled) begin
            checks++;
            if (!bus.out_valid || {bus.out_tag, bus.nv, bus.nx, bus.o} !== held) begin
              errors++;
              $display("FAIL stall_hold: got valid=%0b tag=%0h o=%h, required valid=1 tag=%0h o=%h",
                       bus.out_valid, bus.out_tag, bus.o, held[EW-1 -: TAGWID], held[IWID-1:0]);
            end
          end
          was_stalled = bus.out_valid && !bus.out_ready;
          held = {bus.out_tag, bus.nv, bus.nx, bus.o};
          if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL stall_unexpected: result tag=%0h with nothing pending", bus.out_tag);
            end else begin
              ev = exp_q.pop_front();
              if ({bus.out_tag, bus.nv, bus.nx, bus.o} !== ev) begin
                errors++;
                $display("FAIL stall_result: got tag=%0h nv=%0b nx=%0b o=%h, required tag=%0h nv=%0b nx=%0b o=%h",
                         bus.out_tag, bus.nv, bus.nx, bus.o,
                         ev[EW-1 -: TAGWID], ev[IWID+1], ev[IWID], ev[IWID-1:0]);
              end
            end
            got++;
          end
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        checks++;
        if (got != N) begin
          errors++;
          $display("FAIL stall_count: got %0d results, required %0d", got, N);
        end
      end
    join
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_stream();
    logic saw;
    logic [EW-1:0] ev;
    int cyc;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      drive_op(mk_fp(1'b0, 32'(k + 1), 0), 1'b1, 3'd0, TAGWID'(8'hF0 + k), '0);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_prefill: out_valid got %0b, required 1", bus.out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_tag, bus.nv, bus.nx, bus.o} !== '0) begin
      errors++;
      $display("FAIL mid_async_clear: got valid=%0b tag=%0h o=%h, required all 0",
               bus.out_valid, bus.out_tag, bus.o);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_ready: got %0b, required 1", bus.in_ready);
    end
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      errors++;
      $display("FAIL mid_stale: out_valid seen after reset with no operand, required none");
    end
    @(posedge clk);
    #1;
    drive_op(mk_fp(1'b1, 7, 2), 1'b1, 3'd0, 8'hA5, model(1'b1, 7, 2, 1'b1, 3'd0, 8'hA5));
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.out_valid && cyc < 20);
    checks++;
    if (!bus.out_valid || exp_q.size() == 0) begin
      errors++;
      $display("FAIL mid_fresh_timeout: out_valid got %0b after %0d cycles, required 1", bus.out_valid, cyc);
    end else begin
      ev = exp_q.pop_front();
      if ({bus.out_tag, bus.nv, bus.nx, bus.o} !== ev) begin
        errors++;
        $display("FAIL mid_fresh_result: got tag=%0h o=%h, required tag=%0h o=%h",
                 bus.out_tag, bus.o, ev[EW-1 -: TAGWID], ev[IWID-1:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.i         = '0;
    bus.op        = 1'b0;
    bus.rm        = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_latency();
    test_back_to_back();
    test_stall_stream();
    test_reset_mid_stream();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected results never produced, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
